// File: rtl/tc_pl_adc_merge_pkg.sv
// Shared definitions for the ADC merge front end: sample/word/phase widths,
// lane count and the capture FSM state encoding.
package tc_pl_adc_merge_pkg;
    localparam int ADC0_0 = 14;
    localparam int ADC0_1 = 56;
    localparam int ADC0_2 = 2;
    localparam int LANES  = 4;

    typedef enum logic [1:0] {IDLE, SKIP, PACK, DONE} state_t;
endpackage

// File: rtl/tc_pl_merge_fifo.sv
// Synchronous show-ahead FIFO: rdata is the head entry whenever empty is low.
// A push while full is accepted only if a pop happens in the same cycle.
module tc_pl_merge_fifo #(
    parameter int WIDTH = 56,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

    assign rdata = mem[rptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
endmodule

// File: rtl/tc_pl_adc_merge.sv
// Capture front end: skips phase samples after a trigger, packs four ADC
// samples per word into a FIFO and streams cap_len words out on valid/ready.
module tc_pl_adc_merge #(
    parameter int ADC0_0 = tc_pl_adc_merge_pkg::ADC0_0,
    parameter int ADC0_1 = tc_pl_adc_merge_pkg::ADC0_1,
    parameter int ADC0_2 = tc_pl_adc_merge_pkg::ADC0_2,
    parameter int FDEPTH = 16,
    parameter int LEN_W  = 16
) (
    input  logic              clk125,
    input  logic              rst,
    input  logic [ADC0_0-1:0] Gc_adc_data,
    input  logic              Gc_adc_of,
    input  logic              Gc_cap_trig,
    input  logic [ADC0_2-1:0] Gc_cap_phase,
    input  logic [LEN_W-1:0]  cap_len,
    output logic              Gc_capr_rdy,
    output logic [ADC0_1-1:0] Gc_merge_data,
    output logic              Gc_mereg_datv,
    input  logic              Gc_mereg_datr,
    output logic              merge_of,
    output logic              merge_ovf
);
    import tc_pl_adc_merge_pkg::*;

    localparam int LIDX_W = $clog2(LANES);
    localparam int CNT_W  = $clog2(FDEPTH) + 1;

    state_t             state;
    logic [ADC0_2-1:0]  skip_cnt;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   word_cnt;
    logic [LIDX_W-1:0]  lane;
    logic [ADC0_0-1:0]  lane_q [LANES-1];
    logic [ADC0_1-1:0]  word;
    logic               lane_last;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ADC0_1-1:0]  fifo_rdata;
    logic [CNT_W-1:0]   fifo_count;

    assign lane_last = (lane == LIDX_W'(LANES - 1));
    assign push      = (state == PACK) && lane_last;
    assign pop       = !fifo_empty && Gc_mereg_datr;

    // Lane 0 lands in the LSBs; the live sample completes the top lane.
    always_comb begin
        word = '0;
        for (int i = 0; i < LANES - 1; i++)
            word[i*ADC0_0 +: ADC0_0] = lane_q[i];
        word[(LANES-1)*ADC0_0 +: ADC0_0] = Gc_adc_data;
    end

    always_ff @(posedge clk125) begin
        if (state == PACK && !lane_last) lane_q[lane] <= Gc_adc_data;
    end

    always_ff @(posedge clk125 or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            Gc_capr_rdy <= 1'b0;
            skip_cnt    <= '0;
            len_q       <= '0;
            word_cnt    <= '0;
            lane        <= '0;
            merge_of    <= 1'b0;
            merge_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    Gc_capr_rdy <= 1'b1;
                    if (Gc_cap_trig) begin
                        Gc_capr_rdy <= 1'b0;
                        skip_cnt    <= Gc_cap_phase;
                        len_q       <= cap_len;
                        word_cnt    <= '0;
                        lane        <= '0;
                        merge_of    <= 1'b0;
                        merge_ovf   <= 1'b0;
                        if (cap_len == '0)             state <= DONE;
                        else if (Gc_cap_phase != '0)   state <= SKIP;
                        else                           state <= PACK;
                    end
                end
                SKIP: begin
                    skip_cnt <= skip_cnt - ADC0_2'(1);
                    if (skip_cnt == ADC0_2'(1)) state <= PACK;
                end
                PACK: begin
                    merge_of <= merge_of | Gc_adc_of;
                    lane     <= lane + LIDX_W'(1);
                    if (lane_last) begin
                        // A dropped word still counts toward the requested length.
                        if (fifo_full && !pop) merge_ovf <= 1'b1;
                        word_cnt <= word_cnt + LEN_W'(1);
                        if (word_cnt + LEN_W'(1) == len_q) state <= DONE;
                    end
                end
                DONE: begin
                    // Leave on the edge that pops the last word so ready rises right after it.
                    if (fifo_empty || (pop && fifo_count == CNT_W'(1))) begin
                        state       <= IDLE;
                        Gc_capr_rdy <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    tc_pl_merge_fifo #(
        .WIDTH (ADC0_1),
        .DEPTH (FDEPTH)
    ) u_fifo (
        .clk   (clk125),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (word),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign Gc_mereg_datv = !fifo_empty;
    assign Gc_merge_data = fifo_empty ? '0 : fifo_rdata;
endmodule

// File: tb/tb_tc_pl_adc_merge.sv
// Bench for tc_pl_adc_merge: directed and randomized captures checked every
// cycle against a queue-based reference of kept samples and stored words.
module tb_tc_pl_adc_merge;
    logic        clk125 = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] adc_data = '0;
    logic        adc_of = 1'b0;
    logic        cap_trig = 1'b0;
    logic [1:0]  cap_phase = '0;
    logic [15:0] cap_len = '0;
    logic        datr = 1'b0;
    logic        capr_rdy;
    logic [55:0] merge_data;
    logic        datv;
    logic        merge_of;
    logic        merge_ovf;

    tc_pl_adc_merge dut (
        .clk125        (clk125),
        .rst           (rst),
        .Gc_adc_data   (adc_data),
        .Gc_adc_of     (adc_of),
        .Gc_cap_trig   (cap_trig),
        .Gc_cap_phase  (cap_phase),
        .cap_len       (cap_len),
        .Gc_capr_rdy   (capr_rdy),
        .Gc_merge_data (merge_data),
        .Gc_mereg_datv (datv),
        .Gc_mereg_datr (datr),
        .merge_of      (merge_of),
        .merge_ovf     (merge_ovf)
    );

    always #4 clk125 = ~clk125;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // Reference: capture in progress, kept-sample staging, stored words.
    logic [55:0] mq[$];
    logic [13:0] pend[$];
    logic [55:0] dut_popped[$];
    bit   busy = 0, live = 0, m_of = 0, m_ovf = 0;
    int   t_trig = 0, m_phase = 0, m_len = 0, words = 0, cyc = 0;
    int   of_cyc = -1, first_datv = -1, ramp_val = 0;
    bit   ramp_mode = 0, rand_datr = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("datv", {63'd0, datv}, {63'd0, mq.size() != 0});
        if (mq.size() != 0) chk("data", {8'd0, merge_data}, {8'd0, mq[0]});
        chk("rdy", {63'd0, capr_rdy}, {63'd0, live && !busy});
        chk("merge_of", {63'd0, merge_of}, {63'd0, m_of});
        chk("merge_ovf", {63'd0, merge_ovf}, {63'd0, m_ovf});
        if (datv && first_datv < 0) first_datv = cyc - t_trig - 1;
        if (datv && datr) dut_popped.push_back(merge_data);
    endtask

    task automatic model_edge();
        bit pop, push;
        logic [55:0] w;
        pop  = (mq.size() != 0) && datr;
        push = 0;
        w    = '0;
        if (busy) begin
            if (cyc > t_trig + m_phase && words < m_len) begin
                pend.push_back(adc_data);
                if (adc_of) m_of = 1;
                if (pend.size() == 4) begin
                    w = {pend[3], pend[2], pend[1], pend[0]};
                    pend.delete();
                    words++;
                    if (mq.size() < 16 || pop) push = 1;
                    else m_ovf = 1;
                end
            end
        end else if (cap_trig) begin
            busy = 1; t_trig = cyc; m_phase = int'(cap_phase); m_len = int'(cap_len);
            words = 0; pend.delete(); m_of = 0; m_ovf = 0;
        end
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(w);
        if (busy && t_trig != cyc && words == m_len && mq.size() == 0) busy = 0;
        live = 1;
        cyc++;
    endtask

    task automatic tick();
        adc_data = ramp_mode ? ramp_val[13:0] : 14'($urandom);
        ramp_val++;
        adc_of = (cyc == of_cyc);
        if (rand_datr) datr = 1'($urandom);
        @(negedge clk125);
        check_outputs();
        @(posedge clk125);
        model_edge();
        #1;
        cap_trig = 1'b0;
    endtask

    task automatic start_cap(input int phase, input int len);
        cap_trig  = 1'b1;
        cap_phase = 2'(phase);
        cap_len   = 16'(len);
        dut_popped.delete();
        first_datv = -1;
        tick();
    endtask

    task automatic run_until_idle(input int limit);
        int n = 0;
        while (busy && n < limit) begin
            tick();
            n++;
        end
        chk("capture_end_rdy", {63'd0, capr_rdy}, 64'd1);
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_datv"}, {63'd0, datv}, 64'd0);
        chk({tag, "_rdy"}, {63'd0, capr_rdy}, 64'd0);
        chk({tag, "_of"}, {63'd0, merge_of}, 64'd0);
        chk({tag, "_ovf"}, {63'd0, merge_ovf}, 64'd0);
    endtask

    initial begin
        // Power-on reset
        repeat (3) begin
            @(negedge clk125);
            reset_check("por");
        end
        @(posedge clk125);
        #1 rst = 1'b0;

        // Ramp, phase 0, two words
        datr = 1'b1; ramp_mode = 1; ramp_val = -1;
        start_cap(0, 2);
        run_until_idle(50);
        chk("t1_npop", 64'(dut_popped.size()), 64'd2);
        chk("t1_w0", {8'd0, dut_popped[0]}, {8'd0, 14'd3, 14'd2, 14'd1, 14'd0});
        chk("t1_w1", {8'd0, dut_popped[1]}, {8'd0, 14'd7, 14'd6, 14'd5, 14'd4});

        // Ramp, phase 3: first word and datv latency
        ramp_val = -1;
        start_cap(3, 2);
        run_until_idle(50);
        chk("t2_w0", {8'd0, dut_popped[0]}, {8'd0, 14'd6, 14'd5, 14'd4, 14'd3});
        chk("t2_datv_lat", 64'(first_datv), 64'd7);

        // Back-pressure overflow
        ramp_mode = 0; datr = 1'b0;
        start_cap($urandom_range(0, 3), 20);
        for (int n = 0; n < 200 && words < 20; n++) tick();
        repeat (3) tick();
        chk("t3_ovf", {63'd0, merge_ovf}, 64'd1);
        chk("t3_datv", {63'd0, datv}, 64'd1);
        datr = 1'b1;
        run_until_idle(100);
        chk("t3_npop", 64'(dut_popped.size()), 64'd16);

        // Overrange on a kept sample, then only on a skipped one
        of_cyc = cyc + 4;
        start_cap(2, 1);
        run_until_idle(50);
        repeat (3) tick();
        chk("t4_of_kept", {63'd0, merge_of}, 64'd1);
        of_cyc = cyc + 2;
        start_cap(2, 1);
        run_until_idle(50);
        chk("t4_of_skip", {63'd0, merge_of}, 64'd0);

        // Zero length, then a trigger during PACK
        start_cap($urandom_range(0, 3), 0);
        tick();
        tick();
        chk("t5_len0_rdy", {63'd0, capr_rdy}, 64'd1);
        chk("t5_len0_datv", {63'd0, datv}, 64'd0);
        start_cap(0, 3);
        repeat (5) tick();
        cap_trig = 1'b1; cap_len = 16'd1;
        tick();
        run_until_idle(80);
        chk("t5_ignored_trig", 64'(dut_popped.size()), 64'd3);

        // Asynchronous reset with five words queued mid-capture
        datr = 1'b0;
        start_cap($urandom_range(0, 3), 10);
        for (int n = 0; n < 100 && mq.size() < 5; n++) tick();
        rst = 1'b1;
        #1;
        reset_check("midrst");
        mq.delete(); pend.delete();
        busy = 0; live = 0; m_of = 0; m_ovf = 0;
        repeat (2) @(posedge clk125);
        #1 rst = 1'b0;
        tick();
        chk("post_rst_rdy", {63'd0, capr_rdy}, 64'd1);
        datr = 1'b1; ramp_mode = 1; ramp_val = -1;
        start_cap(1, 3);
        run_until_idle(60);
        chk("post_rst_w0", {8'd0, dut_popped[0]}, {8'd0, 14'd4, 14'd3, 14'd2, 14'd1});

        // Randomized captures under random back-pressure
        ramp_mode = 0; rand_datr = 1;
        repeat (8) begin
            start_cap($urandom_range(0, 3), $urandom_range(1, 6));
            run_until_idle(400);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
